// File: rtl/axi_budget_regulator.sv
`timescale 1ns/1ps
// Per-period AR/AW admission regulator: caps address handshakes per replenishment period
// and total in-flight transactions; B/R channels are only observed.
module axi_budget_regulator #(
    parameter int PERIOD_CYCLES   = 1000,
    parameter int BUDGET_WIDTH    = 16,
    parameter int MAX_OUTSTANDING = 8,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    enable,
    input  logic [BUDGET_WIDTH-1:0] budget_cfg,
    input  logic                    s00_axi_arvalid,
    output logic                    s00_axi_arready,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    input  logic                    s00_axi_awvalid,
    output logic                    s00_axi_awready,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    input  logic                    m00_axi_bvalid,
    input  logic                    m00_axi_bready,
    input  logic                    m00_axi_rvalid,
    input  logic                    m00_axi_rready,
    input  logic                    m00_axi_rlast,
    output logic [BUDGET_WIDTH-1:0] budget_left,
    output logic [OW-1:0]           outstanding,
    output logic                    throttled,
    output logic                    period_tick,
    output logic                    resp_underflow
);

    localparam int SW = OW + 2;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [OW-1:0] MAX_OUT     = OW'(MAX_OUTSTANDING);

    logic [PW-1:0]           period_q;
    logic [BUDGET_WIDTH-1:0] budget_q;
    logic                    fresh_q;
    logic [OW-1:0]           outs_q;
    logic                    rr_q;
    logic                    throttled_q;
    logic                    underflow_q;

    logic                    tick;
    logic [BUDGET_WIDTH-1:0] budget_eff;
    logic [OW-1:0]           room;
    logic                    budget_empty;
    logic                    slots_zero;
    logic                    slots_ge2;
    logic                    slots_one;
    logic                    contend;
    logic                    allow_ar;
    logic                    allow_aw;
    logic                    ar_acc;
    logic                    aw_acc;
    logic                    b_done;
    logic                    r_done;
    logic [1:0]              consumed;
    logic [BUDGET_WIDTH:0]   budget_sub;
    logic [BUDGET_WIDTH-1:0] budget_nxt;
    logic [SW-1:0]           outs_sum;
    logic                    outs_neg;
    logic [OW-1:0]           outs_nxt;

    // Until the first clock after reset release the budget tracks budget_cfg directly.
    assign budget_eff   = fresh_q ? budget_cfg : budget_q;
    assign tick         = (period_q == PERIOD_LAST);
    assign room         = MAX_OUT - outs_q;
    assign budget_empty = (budget_eff == '0);

    assign slots_zero = (enable & budget_empty) | (room == '0);
    assign slots_ge2  = (~enable | (budget_eff > BUDGET_WIDTH'(1))) & (room > OW'(1));
    assign slots_one  = ~slots_zero & ~slots_ge2;
    assign contend    = slots_one & s00_axi_arvalid & s00_axi_awvalid;

    assign allow_ar = slots_ge2 | (slots_one & (~s00_axi_awvalid | ~rr_q));
    assign allow_aw = slots_ge2 | (slots_one & (~s00_axi_arvalid | rr_q));

    assign m00_axi_arvalid = s00_axi_arvalid & allow_ar;
    assign s00_axi_arready = m00_axi_arready & allow_ar;
    assign m00_axi_awvalid = s00_axi_awvalid & allow_aw;
    assign s00_axi_awready = m00_axi_awready & allow_aw;

    assign ar_acc = m00_axi_arvalid & m00_axi_arready;
    assign aw_acc = m00_axi_awvalid & m00_axi_awready;
    assign b_done = m00_axi_bvalid & m00_axi_bready;
    assign r_done = m00_axi_rvalid & m00_axi_rready & m00_axi_rlast;

    always_comb begin
        consumed   = {1'b0, ar_acc} + {1'b0, aw_acc};
        budget_sub = {1'b0, budget_eff} - (BUDGET_WIDTH + 1)'(consumed);
        if (tick) begin
            budget_nxt = budget_cfg;
        end else if (budget_sub[BUDGET_WIDTH]) begin
            budget_nxt = '0;
        end else begin
            budget_nxt = budget_sub[BUDGET_WIDTH-1:0];
        end

        // Signed in SW bits: the MSB flags a completion with nothing in flight.
        outs_sum = SW'(outs_q) + SW'(ar_acc) + SW'(aw_acc) - SW'(b_done) - SW'(r_done);
        outs_neg = outs_sum[SW-1];
        outs_nxt = outs_neg ? '0 : outs_sum[OW-1:0];
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            period_q    <= '0;
            budget_q    <= '0;
            fresh_q     <= 1'b1;
            outs_q      <= '0;
            rr_q        <= 1'b0;
            throttled_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            period_q    <= tick ? '0 : period_q + PW'(1);
            budget_q    <= budget_nxt;
            fresh_q     <= 1'b0;
            outs_q      <= outs_nxt;
            if (contend && (ar_acc || aw_acc)) begin
                rr_q <= ~rr_q;
            end
            throttled_q <= enable & (s00_axi_arvalid | s00_axi_awvalid) & budget_empty;
            underflow_q <= underflow_q | outs_neg;
        end
    end

    assign budget_left    = budget_eff;
    assign outstanding    = outs_q;
    assign throttled      = throttled_q;
    assign period_tick    = tick;
    assign resp_underflow = underflow_q;

endmodule
